// File: rtl/ofdm_symbol_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_symbol_sequencer
// Purpose  : Frames FFT symbols into LTF1/LTF2/data pulses for the channel
//            estimator and equalizer, with restart and timeout recovery.
//            Optional macro OFDM_LTF_AVG_EN also issues the second LTF.
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_symbol_sequencer #(
  parameter int DATASYMS = 12,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic       sym_valid_i,
  output logic       ltf_valid_o,
  output logic       ltf_second_o,
  output logic       data_valid_o,
  output logic [7:0] sym_idx_o,
  output logic       frame_done_o,
  output logic       busy_o,
  output logic [1:0] err_o
);

  localparam logic [1:0]  c_IDLE        = 2'd0;
  localparam logic [1:0]  c_LTF1        = 2'd1;
  localparam logic [1:0]  c_LTF2        = 2'd2;
  localparam logic [1:0]  c_DATA        = 2'd3;
  localparam logic [1:0]  c_ERR_NONE    = 2'b00;
  localparam logic [1:0]  c_ERR_RESTART = 2'b01;
  localparam logic [1:0]  c_ERR_TIMEOUT = 2'b10;
  localparam logic [7:0]  c_LAST_SYM    = 8'(DATASYMS - 1);
  localparam logic [15:0] c_TO_LAST     = 16'(TIMEOUT - 1);

  logic [1:0]  r_state, w_state_nxt;
  logic [7:0]  r_dcnt, w_dcnt_nxt;
  logic [15:0] r_tcnt, w_tcnt_nxt;
  logic        w_busy_now, w_timeout, w_last;
  logic        r_ltf_valid, w_ltf_valid;
  logic        r_data_valid, w_data_valid;
  logic        r_frame_done, w_frame_done;
  logic        r_busy;
  logic [7:0]  r_sym_idx, w_sym_idx;
  logic [1:0]  r_err, w_err;

  assign w_busy_now = (r_state != c_IDLE);
  assign w_last     = (r_dcnt == c_LAST_SYM);
  // A symbol or a restart in the expiry cycle keeps the frame alive.
  assign w_timeout  = w_busy_now && !frame_start_i && !sym_valid_i && (r_tcnt == c_TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= c_IDLE;
      r_dcnt       <= '0;
      r_tcnt       <= '0;
      r_ltf_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_sym_idx    <= '0;
      r_err        <= c_ERR_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_dcnt       <= w_dcnt_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_ltf_valid  <= w_ltf_valid;
      r_data_valid <= w_data_valid;
      r_frame_done <= w_frame_done;
      r_busy       <= (w_state_nxt != c_IDLE);
      r_sym_idx    <= w_sym_idx;
      r_err        <= w_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start_i) begin
      w_state_nxt = c_LTF1;
    end else if (sym_valid_i) begin
      case (r_state)
        c_LTF1:  w_state_nxt = c_LTF2;
        c_LTF2:  w_state_nxt = c_DATA;
        c_DATA:  w_state_nxt = w_last ? c_IDLE : c_DATA;
        default: w_state_nxt = c_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = c_IDLE;
    end
  end

  always_comb begin
    w_ltf_valid  = 1'b0;
    w_data_valid = 1'b0;
    w_frame_done = 1'b0;
    w_sym_idx    = r_sym_idx;
    w_dcnt_nxt   = r_dcnt;
    w_err        = r_err;
    w_tcnt_nxt   = (frame_start_i || sym_valid_i || !w_busy_now) ? 16'd0 : r_tcnt + 16'd1;
    if (frame_start_i) begin
      w_sym_idx  = '0;
      w_dcnt_nxt = '0;
      w_err      = w_busy_now ? c_ERR_RESTART : c_ERR_NONE;
    end else begin
      if (sym_valid_i) begin
        w_ltf_valid  = (r_state == c_LTF1);
        w_data_valid = (r_state == c_DATA);
`ifdef OFDM_LTF_AVG_EN
        if (r_state == c_LTF2) w_ltf_valid = 1'b1;
`endif
      end
      if (w_data_valid) begin
        w_sym_idx    = r_dcnt;
        w_dcnt_nxt   = r_dcnt + 8'd1;
        w_frame_done = w_last;
      end
      if (w_timeout) w_err = c_ERR_TIMEOUT;
    end
  end

`ifdef OFDM_LTF_AVG_EN
  logic r_ltf_second, w_ltf_second;
  assign w_ltf_second = !frame_start_i && sym_valid_i && (r_state == c_LTF2);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ltf_second <= 1'b0;
    else         r_ltf_second <= w_ltf_second;
  end
  assign ltf_second_o = r_ltf_second;
`else
  assign ltf_second_o = 1'b0;
`endif

  assign ltf_valid_o  = r_ltf_valid;
  assign data_valid_o = r_data_valid;
  assign sym_idx_o    = r_sym_idx;
  assign frame_done_o = r_frame_done;
  assign busy_o       = r_busy;
  assign err_o        = r_err;

endmodule
`default_nettype wire
